regfile_2r1w: RTL and testbench

Parametrised two-read/one-write register file for the datapath, the next generation of the 16x16 single-port-pair register file. It generalises data width and depth and registers both read ports with a valid flag. It adds an optional same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a sequential clear engine so software can wipe the file without asserting reset. It sits between the instruction decoder (addresses, write enable) and the ALU operand muxes.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_2r1w_if.sv | 36 +++
 rtl/regfile_clear_seq.sv | 58 +++++
 rtl/regfile_2r1w.sv | 102 ++++++++++
 tb/tb_regfile_2r1w.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types and default sizes for regfile_2r1w
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } regfile_state_e;

  // Address/data pair for one read port, shared with the instruction decoder
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rd_port_t;

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w_if.sv
// ============================================================================
// regfile_2r1w_if : decoder/ALU-side bus of the 2R1W register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] ra1;
  logic              clr_req;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic              rvalid;
  logic              busy;

  modport master (
    output en, we, wa, wd, ra0, ra1, clr_req,
    input  rd0, rd1, rvalid, busy
  );

  modport slave (
    input  en, we, wa, wd, ra0, ra1, clr_req,
    output rd0, rd1, rvalid, busy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// ============================================================================
// regfile_clear_seq : IDLE/CLEAR walker that zeroes every entry in turn
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              clr_req,
  output logic                   busy,
  output logic                   clr_we,
  output logic [ADDR_W-1:0]      clr_addr
);

  localparam logic [0:0]        c_st_idle  = 1'(RF_IDLE);
  localparam logic [0:0]        c_st_clear = 1'(RF_CLEAR);
  localparam logic [ADDR_W-1:0] c_last     = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (clr_req) begin
            r_state <= c_st_clear;
            r_cnt   <= '0;
          end
        end
        c_st_clear: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign busy     = (r_state == c_st_clear);
  assign clr_we   = busy;
  assign clr_addr = r_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// regfile_2r1w : parametrised 2-read/1-write register file, registered reads
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  regfile_2r1w_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_r0_block;
  logic              w_wr_ok;
  logic              w_rd_cap;
  logic              w_hit0;
  logic              w_hit1;
  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [DATA_W-1:0] w_rd0_nxt;
  logic [DATA_W-1:0] w_rd1_nxt;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;
  logic              r_rvalid;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A clear request in IDLE wins over a write on the same edge
  assign w_r0_block = (ZERO_R0 != 0) && (bus.wa == '0);
  assign w_wr_ok    = bus.en && bus.we && !w_busy && !bus.clr_req && !w_r0_block;
  assign w_rd_cap   = bus.en && !w_busy;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_clr_we && (w_clr_addr == ADDR_W'(gi))) begin
        r_q <= '0;
      end else if (w_wr_ok && (bus.wa == ADDR_W'(gi))) begin
        r_q <= bus.wd;
      end
    end
    assign w_mem[gi] = r_q;
  end

`ifdef REGFILE_BYPASS_EN
  assign w_hit0 = w_wr_ok && (bus.ra0 == bus.wa);
  assign w_hit1 = w_wr_ok && (bus.ra1 == bus.wa);
`else
  assign w_hit0 = 1'b0;
  assign w_hit1 = 1'b0;
`endif

  always_comb begin
    w_rd0_nxt = w_hit0 ? bus.wd : w_mem[bus.ra0];
    w_rd1_nxt = w_hit1 ? bus.wd : w_mem[bus.ra1];
    if ((ZERO_R0 != 0) && (bus.ra0 == '0)) w_rd0_nxt = '0;
    if ((ZERO_R0 != 0) && (bus.ra1 == '0)) w_rd1_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd0    <= '0;
      r_rd1    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_cap;
      if (w_rd_cap) begin
        r_rd0 <= w_rd0_nxt;
        r_rd1 <= w_rd1_nxt;
      end
    end
  end

  assign bus.rd0    = r_rd0;
  assign bus.rd1    = r_rd1;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// tb_regfile_2r1w : directed self-checking bench, ZERO_R0=0 and ZERO_R0=1 DUTs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [15:0] wd = '0;
  logic [3:0]  ra0 = '0;
  logic [3:0]  ra1 = '0;
  logic        clr_req = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] byp_exp;

  always #5 clk = ~clk;

  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(4)) if_z ();

  assign if_a.en = en;  assign if_a.we = we;  assign if_a.wa = wa;  assign if_a.wd = wd;
  assign if_a.ra0 = ra0; assign if_a.ra1 = ra1; assign if_a.clr_req = clr_req;
  assign if_z.en = en;  assign if_z.we = we;  assign if_z.wa = wa;  assign if_z.wd = wd;
  assign if_z.ra0 = ra0; assign if_z.ra1 = ra1; assign if_z.clr_req = clr_req;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (if_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    en = 1'b1; we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Asynchronous reset asserted mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("rst_rvalid", 32'(if_a.rvalid), 32'd0);
    chk("rst_busy",   32'(if_a.busy),   32'd0);
    chk("rst_rd0",    32'(if_a.rd0),    32'd0);
    chk("rst_rd1",    32'(if_z.rd1),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    en = 1'b1; ra0 = 4'd3; ra1 = 4'd15;
    tick();
    chk("read_after_rst_rd0", 32'(if_a.rd0), 32'h0000);
    chk("read_after_rst_rd1", 32'(if_a.rd1), 32'h0000);
    chk("read_after_rst_rv",  32'(if_a.rvalid), 32'd1);

    // Write 5 while port 1 reads 5 on the same edge
`ifdef REGFILE_BYPASS_EN
    byp_exp = 16'hBEEF;
`else
    byp_exp = 16'h0000;
`endif
    ra1 = 4'd5;
    wr(4'd5, 16'hBEEF);
    chk("collide_rd1", 32'(if_a.rd1), 32'(byp_exp));
    ra0 = 4'd5;
    tick();
    chk("wr_then_rd0", 32'(if_a.rd0), 32'hBEEF);

    // Zero-register behaviour
    wr(4'd1, 16'h0101);
`ifdef REGFILE_BYPASS_EN
    byp_exp = 16'h1234;
`else
    byp_exp = 16'h0000;
`endif
    ra0 = 4'd0;
    wr(4'd0, 16'h1234);
    chk("r0_collide_a", 32'(if_a.rd0), 32'(byp_exp));
    chk("r0_collide_z", 32'(if_z.rd0), 32'h0000);
    ra0 = 4'd0; ra1 = 4'd1;
    tick();
    chk("r0_read_a",  32'(if_a.rd0), 32'h1234);
    chk("r0_read_z",  32'(if_z.rd0), 32'h0000);
    chk("r1_intact_z", 32'(if_z.rd1), 32'h0101);

    // en gating
    wr(4'd2, 16'h2222);
    ra0 = 4'd2;
    tick();
    chk("en_pre_rd0", 32'(if_a.rd0), 32'h2222);
    en = 1'b0; we = 1'b1; wa = 4'd2; wd = 16'hAAAA; ra0 = 4'd5;
    tick();
    chk("en0_rvalid", 32'(if_a.rvalid), 32'd0);
    chk("en0_rd_hold", 32'(if_a.rd0), 32'h2222);
    en = 1'b1; we = 1'b0; ra0 = 4'd2;
    tick();
    chk("en0_no_write", 32'(if_a.rd0), 32'h2222);
    chk("en1_rvalid",   32'(if_a.rvalid), 32'd1);

    // Clear sequence: preload 0x1111*i, then request clear with a colliding write
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'h1111 * i));
    en = 1'b1; we = 1'b1; wa = 4'd7; wd = 16'hFFFF; ra0 = 4'd7; ra1 = 4'd7; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_edge_busy", 32'(if_a.busy), 32'd1);
    chk("clr_edge_rd0",  32'(if_a.rd0),  32'h7777);
    chk("clr_edge_rv",   32'(if_a.rvalid), 32'd1);
    wa = 4'd3; wd = 16'h5555;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("clr_busy_%0d", k), 32'(if_a.busy), (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("clr_rv_%0d", k), 32'(if_a.rvalid), 32'd0);
      chk($sformatf("clr_hold_%0d", k), 32'(if_a.rd1), 32'h7777);
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); ra1 = 4'(i);
      tick();
      chk($sformatf("clr_zero_a_%0d", i), 32'(if_a.rd0), 32'h0000);
      chk($sformatf("clr_zero_z_%0d", i), 32'(if_z.rd1), 32'h0000);
    end
    wr(4'd9, 16'h9999);
    ra0 = 4'd9;
    tick();
    chk("post_clr_write", 32'(if_a.rd0), 32'h9999);

    // Reset part-way through a clear
    wr(4'd4, 16'h4444);
    wr(4'd10, 16'hA0A0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    chk("pre_abort_busy", 32'(if_a.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(if_a.busy), 32'd0);
    chk("abort_rv",   32'(if_a.rvalid), 32'd0);
    #1 rst = 1'b0;
    ra0 = 4'd4; ra1 = 4'd10; en = 1'b1;
    tick();
    chk("abort_rd4",  32'(if_a.rd0), 32'h0000);
    chk("abort_rd10", 32'(if_a.rd1), 32'h0000);
    ra0 = 4'd9;
    tick();
    chk("abort_rd9",  32'(if_a.rd0), 32'h0000);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("reclr_busy", 32'(if_a.busy), 32'd1);
    repeat (15) tick();
    chk("reclr_busy_last", 32'(if_a.busy), 32'd1);
    tick();
    chk("reclr_done", 32'(if_a.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
